// File: rtl/multi_cycle_controller_pkg.sv
// mips_pkg: shared states, opcodes, functs and select encodings
// for the multicycle MIPS controller. HALT exists only with ILLEGAL_TRAP_EN.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEM_ADR = 4'd2,
      S_MEM_RD  = 4'd3,
      S_MEM_WB  = 4'd4,
      S_MEM_WR  = 4'd5,
      S_EXEC    = 4'd6,
      S_SHIFT   = 4'd7,
      S_ALU_WB  = 4'd8,
      S_ADDI_EX = 4'd9,
      S_ADDI_WB = 4'd10,
      S_BRANCH  = 4'd11,
      S_JUMP    = 4'd12,
      S_JR      = 4'd13
`ifdef ILLEGAL_TRAP_EN
      , S_HALT  = 4'd14
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCA_PC   = 2'd0;
   localparam logic [1:0] SRCA_REG1 = 2'd1;
   localparam logic [1:0] SRCA_REG2 = 2'd2;

   localparam logic [2:0] SRCB_REG2  = 3'd0;
   localparam logic [2:0] SRCB_FOUR  = 3'd1;
   localparam logic [2:0] SRCB_IMM   = 3'd2;
   localparam logic [2:0] SRCB_IMMSH = 3'd3;
   localparam logic [2:0] SRCB_SHAMT = 3'd4;

   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUREG = 2'd1;
   localparam logic [1:0] PCS_JUMP   = 2'd2;
   localparam logic [1:0] PCS_REG1   = 2'd3;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Control bus between the multicycle controller and the MIPS datapath.
// master = controller (drives controls), slave = datapath (drives opcode/funct/zero).
interface multi_cycle_controller_if;

   logic [5:0] operation;
   logic [5:0] func;
   logic       zero;
   logic       pc_reg_we;
   logic       instr_reg_we;
   logic       instr_or_data;
   logic       mem_we;
   logic       reg_we;
   logic       reg_write_addr;
   logic       reg_write_data;
   logic [1:0] alu_src_a;
   logic [2:0] alu_src_b;
   logic [1:0] pc_src;
   logic [2:0] alu_controller;

   modport master (
      input  operation, func, zero,
      output pc_reg_we, instr_reg_we, instr_or_data,
      output mem_we, reg_we, reg_write_addr,
      output reg_write_data, alu_src_a, alu_src_b,
      output pc_src, alu_controller
   );

   modport slave (
      output operation, func, zero,
      input  pc_reg_we, instr_reg_we, instr_or_data,
      input  mem_we, reg_we, reg_write_addr,
      input  reg_write_data, alu_src_a, alu_src_b,
      input  pc_src, alu_controller
   );

endinterface

// File: rtl/multi_cycle_controller_alu_decoder.sv
// alu_decoder: R-type funct -> ALU op, flags functs the controller
// cannot execute. Ports: func in, alu_op out, unknown out.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] func,
   output logic [2:0] alu_op,
   output logic       unknown
);

   always_comb begin
      alu_op  = ALU_ADD;
      unknown = 1'b0;
      unique case (1'b1)
         (func == FN_ADD): alu_op = ALU_ADD;
         (func == FN_SUB): alu_op = ALU_SUB;
         (func == FN_AND): alu_op = ALU_AND;
         (func == FN_OR):  alu_op = ALU_OR;
         (func == FN_SLT): alu_op = ALU_SLT;
         (func == FN_SLL): alu_op = ALU_SLL;
         (func == FN_SRL): alu_op = ALU_SRL;
         (func == FN_JR):  alu_op = ALU_ADD;
         default:          unknown = 1'b1;
      endcase
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: multicycle MIPS control FSM (clk, rst, bus master,
// illegal_instr, state_o debug). Macro ILLEGAL_TRAP_EN enables HALT on illegal ops.
module multi_cycle_controller
   import mips_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   multi_cycle_controller_if.master bus,
   output logic                   illegal_instr,
   output logic [STATE_W-1:0]     state_o
);

   state_t     state, next;
   state_t     dec_next, bad_next;
   logic [2:0] fn_alu;
   logic       fn_bad;
   logic       op_r, fn_jr, fn_shift;

   logic       pc_we_c, ir_we_c, mem_we_c, reg_we_c;
   logic       iod_c, wa_c, wd_c;
   logic [1:0] src_a_c, pc_src_c;
   logic [2:0] src_b_c, alu_c;

   alu_decoder u_alu_dec (
      .func    (bus.func),
      .alu_op  (fn_alu),
      .unknown (fn_bad)
   );

   assign op_r     = (bus.operation == OP_RTYPE);
   assign fn_jr    = (bus.func == FN_JR);
   assign fn_shift = (bus.func == FN_SLL) ||
                     (bus.func == FN_SRL);

`ifdef ILLEGAL_TRAP_EN
   assign bad_next = S_HALT;
`else
   assign bad_next = S_FETCH;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= next;
   end

   always_comb begin
      dec_next = bad_next;
      unique case (1'b1)
         (bus.operation == OP_LW),
         (bus.operation == OP_SW):
            dec_next = S_MEM_ADR;
         (op_r && !fn_bad && fn_jr):
            dec_next = S_JR;
         (op_r && !fn_bad && fn_shift):
            dec_next = S_SHIFT;
         (op_r && !fn_bad && !fn_jr && !fn_shift):
            dec_next = S_EXEC;
         (bus.operation == OP_BEQ),
         (bus.operation == OP_BNE):
            dec_next = S_BRANCH;
         (bus.operation == OP_ADDI):
            dec_next = S_ADDI_EX;
         (bus.operation == OP_J):
            dec_next = S_JUMP;
         default:
            dec_next = bad_next;
      endcase
   end

   always_comb begin
      next = S_FETCH;
      unique case (state)
         S_FETCH:   next = S_DECODE;
         S_DECODE:  next = dec_next;
         S_MEM_ADR: next = (bus.operation == OP_SW) ?
                           S_MEM_WR : S_MEM_RD;
         S_MEM_RD:  next = S_MEM_WB;
         S_EXEC:    next = S_ALU_WB;
         S_SHIFT:   next = S_ALU_WB;
         S_ADDI_EX: next = S_ADDI_WB;
`ifdef ILLEGAL_TRAP_EN
         S_HALT:    next = S_HALT;
`endif
         default:   next = S_FETCH;
      endcase
   end

   always_comb begin
      pc_we_c  = 1'b0;
      ir_we_c  = 1'b0;
      mem_we_c = 1'b0;
      reg_we_c = 1'b0;
      iod_c    = 1'b0;
      wa_c     = 1'b0;
      wd_c     = 1'b0;
      src_a_c  = SRCA_PC;
      src_b_c  = SRCB_REG2;
      pc_src_c = PCS_ALU;
      alu_c    = ALU_ADD;
      unique case (state)
         S_FETCH: begin
            ir_we_c = 1'b1;
            pc_we_c = 1'b1;
            src_b_c = SRCB_FOUR;
         end
         S_DECODE: src_b_c = SRCB_IMMSH;
         S_MEM_ADR, S_ADDI_EX: begin
            src_a_c = SRCA_REG1;
            src_b_c = SRCB_IMM;
         end
         S_MEM_RD: iod_c = 1'b1;
         S_MEM_WB: begin
            reg_we_c = 1'b1;
            wd_c     = 1'b1;
         end
         S_MEM_WR: begin
            iod_c    = 1'b1;
            mem_we_c = 1'b1;
         end
         S_EXEC: begin
            src_a_c = SRCA_REG1;
            alu_c   = fn_alu;
         end
         S_SHIFT: begin
            src_a_c = SRCA_REG2;
            src_b_c = SRCB_SHAMT;
            alu_c   = fn_alu;
         end
         S_ALU_WB: begin
            reg_we_c = 1'b1;
            wa_c     = 1'b1;
         end
         S_ADDI_WB: reg_we_c = 1'b1;
         S_BRANCH: begin
            src_a_c  = SRCA_REG1;
            alu_c    = ALU_SUB;
            pc_src_c = PCS_ALUREG;
            // Mealy: branch resolves on the live zero flag
            pc_we_c  = ((bus.operation == OP_BEQ) && bus.zero) ||
                       ((bus.operation == OP_BNE) && !bus.zero);
         end
         S_JUMP: begin
            pc_src_c = PCS_JUMP;
            pc_we_c  = 1'b1;
         end
         S_JR: begin
            pc_src_c = PCS_REG1;
            pc_we_c  = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset parks us in FETCH, whose enables must stay low until release
   assign bus.pc_reg_we      = pc_we_c  & ~rst;
   assign bus.instr_reg_we   = ir_we_c  & ~rst;
   assign bus.mem_we         = mem_we_c & ~rst;
   assign bus.reg_we         = reg_we_c & ~rst;
   assign bus.instr_or_data  = iod_c;
   assign bus.reg_write_addr = wa_c;
   assign bus.reg_write_data = wd_c;
   assign bus.alu_src_a      = src_a_c;
   assign bus.alu_src_b      = src_b_c;
   assign bus.pc_src         = pc_src_c;
   assign bus.alu_controller = alu_c;

`ifdef ILLEGAL_TRAP_EN
   assign illegal_instr = (state == S_HALT);
`else
   assign illegal_instr = 1'b0;
`endif

   assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller; covers ILLEGAL_TRAP_EN both ways.
// Samples 1 time unit after the rising edge; inputs act as the instruction register.
module tb_multi_cycle_controller;
   import mips_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       illegal_instr;
   logic [3:0] state_o;
   int         n_cmp = 0;
   int         n_err = 0;

   multi_cycle_controller_if bus ();

   multi_cycle_controller #(.STATE_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .illegal_instr (illegal_instr),
      .state_o       (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic st(input string tag, input state_t s);
      chk(tag, 32'(state_o), 32'(s));
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   // Called while in FETCH; checks FETCH and DECODE cycles
   task automatic fetch_dec(input string tag,
                            input logic [5:0] op,
                            input logic [5:0] fn);
      bus.operation = op;
      bus.func      = fn;
      bus.zero      = 1'b0;
      #1;
      st({tag, "_fetch"}, S_FETCH);
      chk({tag, "_f_irwe"}, 32'(bus.instr_reg_we), 1);
      chk({tag, "_f_pcwe"}, 32'(bus.pc_reg_we), 1);
      chk({tag, "_f_srcb"}, 32'(bus.alu_src_b), 1);
      chk({tag, "_f_alu"}, 32'(bus.alu_controller), 32'h2);
      chk({tag, "_f_iod"}, 32'(bus.instr_or_data), 0);
      cyc;
      st({tag, "_decode"}, S_DECODE);
      chk({tag, "_d_srcb"}, 32'(bus.alu_src_b), 3);
      chk({tag, "_d_pcwe"}, 32'(bus.pc_reg_we), 0);
      chk({tag, "_d_irwe"}, 32'(bus.instr_reg_we), 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.operation = 6'h00;
      bus.func      = 6'h20;
      bus.zero      = 1'b0;
      cyc;
      cyc;
      st("rst_state", S_FETCH);
      chk("rst_pcwe", 32'(bus.pc_reg_we), 0);
      chk("rst_irwe", 32'(bus.instr_reg_we), 0);
      chk("rst_memwe", 32'(bus.mem_we), 0);
      chk("rst_regwe", 32'(bus.reg_we), 0);
      chk("rst_illegal", 32'(illegal_instr), 0);
      rst = 1'b0;
      #1;

      // lw $8,4($0): 5 cycles
      fetch_dec("lw", 6'h23, 6'h04);
      cyc;
      st("lw_madr", S_MEM_ADR);
      chk("lw_ma_srca", 32'(bus.alu_src_a), 1);
      chk("lw_ma_srcb", 32'(bus.alu_src_b), 2);
      cyc;
      st("lw_mrd", S_MEM_RD);
      chk("lw_mr_iod", 32'(bus.instr_or_data), 1);
      chk("lw_mr_regwe", 32'(bus.reg_we), 0);
      cyc;
      st("lw_mwb", S_MEM_WB);
      chk("lw_wb_regwe", 32'(bus.reg_we), 1);
      chk("lw_wb_wd", 32'(bus.reg_write_data), 1);
      chk("lw_wb_wa", 32'(bus.reg_write_addr), 0);
      chk("lw_wb_memwe", 32'(bus.mem_we), 0);
      cyc;
      st("lw_ret", S_FETCH);

      // sw: 4 cycles
      fetch_dec("sw", 6'h2B, 6'h08);
      chk("sw_d_regwe", 32'(bus.reg_we), 0);
      cyc;
      st("sw_madr", S_MEM_ADR);
      chk("sw_ma_regwe", 32'(bus.reg_we), 0);
      cyc;
      st("sw_mwr", S_MEM_WR);
      chk("sw_memwe", 32'(bus.mem_we), 1);
      chk("sw_iod", 32'(bus.instr_or_data), 1);
      chk("sw_regwe", 32'(bus.reg_we), 0);
      cyc;
      st("sw_ret", S_FETCH);

      // beq: Mealy on zero
      fetch_dec("beq", 6'h04, 6'h00);
      cyc;
      st("beq_br", S_BRANCH);
      chk("beq_z0_pcwe", 32'(bus.pc_reg_we), 0);
      bus.zero = 1'b1;
      #1;
      chk("beq_z1_pcwe", 32'(bus.pc_reg_we), 1);
      chk("beq_pcsrc", 32'(bus.pc_src), 1);
      chk("beq_alu", 32'(bus.alu_controller), 32'h6);
      chk("beq_srca", 32'(bus.alu_src_a), 1);
      cyc;
      st("beq_ret", S_FETCH);

      // bne: inverse
      fetch_dec("bne", 6'h05, 6'h00);
      cyc;
      st("bne_br", S_BRANCH);
      chk("bne_z0_pcwe", 32'(bus.pc_reg_we), 1);
      bus.zero = 1'b1;
      #1;
      chk("bne_z1_pcwe", 32'(bus.pc_reg_we), 0);
      chk("bne_pcsrc", 32'(bus.pc_src), 1);
      cyc;
      st("bne_ret", S_FETCH);

      // add: R-type 4 cycles
      fetch_dec("add", 6'h00, 6'h20);
      cyc;
      st("add_exec", S_EXEC);
      chk("add_alu", 32'(bus.alu_controller), 32'h2);
      chk("add_srca", 32'(bus.alu_src_a), 1);
      chk("add_srcb", 32'(bus.alu_src_b), 0);
      cyc;
      st("add_wb", S_ALU_WB);
      chk("add_wb_regwe", 32'(bus.reg_we), 1);
      chk("add_wb_wa", 32'(bus.reg_write_addr), 1);
      chk("add_wb_wd", 32'(bus.reg_write_data), 0);
      cyc;
      st("add_ret", S_FETCH);

      fetch_dec("sub", 6'h00, 6'h22);
      cyc;
      st("sub_exec", S_EXEC);
      chk("sub_alu", 32'(bus.alu_controller), 32'h6);
      cyc;
      cyc;
      st("sub_ret", S_FETCH);

      fetch_dec("slt", 6'h00, 6'h2A);
      cyc;
      st("slt_exec", S_EXEC);
      chk("slt_alu", 32'(bus.alu_controller), 32'h7);
      cyc;
      cyc;
      st("slt_ret", S_FETCH);

      fetch_dec("sll", 6'h00, 6'h00);
      cyc;
      st("sll_shift", S_SHIFT);
      chk("sll_srca", 32'(bus.alu_src_a), 2);
      chk("sll_srcb", 32'(bus.alu_src_b), 4);
      chk("sll_alu", 32'(bus.alu_controller), 32'h3);
      cyc;
      st("sll_wb", S_ALU_WB);
      cyc;
      st("sll_ret", S_FETCH);

      fetch_dec("srl", 6'h00, 6'h02);
      cyc;
      st("srl_shift", S_SHIFT);
      chk("srl_alu", 32'(bus.alu_controller), 32'h4);
      cyc;
      cyc;
      st("srl_ret", S_FETCH);

      // jr: 3 cycles
      fetch_dec("jr", 6'h00, 6'h08);
      cyc;
      st("jr_state", S_JR);
      chk("jr_pcsrc", 32'(bus.pc_src), 3);
      chk("jr_pcwe", 32'(bus.pc_reg_we), 1);
      cyc;
      st("jr_ret", S_FETCH);

      // j: 3 cycles
      fetch_dec("j", 6'h02, 6'h00);
      cyc;
      st("j_state", S_JUMP);
      chk("j_pcsrc", 32'(bus.pc_src), 2);
      chk("j_pcwe", 32'(bus.pc_reg_we), 1);
      cyc;
      st("j_ret", S_FETCH);

      // addi: 4 cycles
      fetch_dec("addi", 6'h08, 6'h05);
      cyc;
      st("addi_ex", S_ADDI_EX);
      chk("addi_srca", 32'(bus.alu_src_a), 1);
      chk("addi_srcb", 32'(bus.alu_src_b), 2);
      cyc;
      st("addi_wb", S_ADDI_WB);
      chk("addi_regwe", 32'(bus.reg_we), 1);
      chk("addi_wa", 32'(bus.reg_write_addr), 0);
      cyc;
      st("addi_ret", S_FETCH);

      // reset during MEM_WR aborts the store
      fetch_dec("swr", 6'h2B, 6'h00);
      cyc;
      cyc;
      st("swr_mwr", S_MEM_WR);
      chk("swr_memwe", 32'(bus.mem_we), 1);
      rst = 1'b1;
      #1;
      chk("swr_abort_memwe", 32'(bus.mem_we), 0);
      st("swr_abort_state", S_FETCH);
      chk("swr_abort_irwe", 32'(bus.instr_reg_we), 0);
      chk("swr_abort_pcwe", 32'(bus.pc_reg_we), 0);
      cyc;
      st("swr_hold_state", S_FETCH);
      chk("swr_hold_memwe", 32'(bus.mem_we), 0);
      rst = 1'b0;
      #1;
      chk("swr_rel_irwe", 32'(bus.instr_reg_we), 1);
      st("swr_rel_state", S_FETCH);

      // illegal opcode 0x3F
      fetch_dec("ill", 6'h3F, 6'h00);
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) begin
         cyc;
         st("ill_halt", S_HALT);
         chk("ill_flag", 32'(illegal_instr), 1);
         chk("ill_pcwe", 32'(bus.pc_reg_we), 0);
         chk("ill_irwe", 32'(bus.instr_reg_we), 0);
      end
      rst = 1'b1;
      #1;
      chk("ill_rst_flag", 32'(illegal_instr), 0);
      st("ill_rst_state", S_FETCH);
      rst = 1'b0;
`else
      cyc;
      st("ill_nop", S_FETCH);
      chk("ill_flag", 32'(illegal_instr), 0);
      chk("ill_irwe", 32'(bus.instr_reg_we), 1);
`endif

      // unknown R-type funct
      bus.operation = 6'h00;
      bus.func      = 6'h3F;
      #1;
      cyc;
      st("badfn_decode", S_DECODE);
      cyc;
`ifdef ILLEGAL_TRAP_EN
      st("badfn_halt", S_HALT);
      chk("badfn_flag", 32'(illegal_instr), 1);
`else
      st("badfn_nop", S_FETCH);
      chk("badfn_flag", 32'(illegal_instr), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
Moore/Mealy control FSM that sits directly upstream of the multicycle MIPS datapath. It consumes the datapath's opcode, funct and ALU zero flag, and drives every mux select, register write enable and the memory write strobe for each instruction step. It issues one instruction at a time, spending 3–5 cycles on each.

Parameters:
STATE_W, 4, width of the debug state output; must be at least 4.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
operation  in  6  instr[31:26] from the instruction register
func  in  6  instr[5:0] from the instruction register
zero  in  1  ALU zero flag, combinational from the datapath
pc_reg_we  out  1  PC register write enable
instr_reg_we  out  1  instruction register write enable
instr_or_data  out  1  memory address select: 0 = pc, 1 = alu_reg_out
mem_we  out  1  data memory write strobe
reg_we  out  1  register file write enable
reg_write_addr  out  1  write-address select: 0 = rt, 1 = rd
reg_write_data  out  1  write-data select: 0 = alu_reg_out, 1 = memory data register
alu_src_a  out  2  ALU A select: 0 = pc, 1 = reg_out1, 2 = reg_out2
alu_src_b  out  3  ALU B select: 0 = reg_out2, 1 = const 4, 2 = imm, 3 = imm<<2, 4 = shamt
pc_src  out  2  next-PC select: 0 = alu_result, 1 = alu_reg_out, 2 = jump target, 3 = reg_out1
alu_controller  out  3  ALU op: AND 000, OR 001, ADD 010, SLL 011, SRL 100, SUB 110, SLT 111
illegal_instr  out  1  illegal-instruction flag (macro-dependent, see Optional Feature)
state_o  out  STATE_W  current state encoding, for debug

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to FETCH immediately.
  - While rst is high, all write enables (pc_reg_we, instr_reg_we, mem_we, reg_we) are forced to 0.
  - illegal_instr resets to 0.
  - First FETCH outputs appear in the first cycle after rst deasserts.
- Default output values in every state unless listed: all enables 0, all selects 0, alu_controller = ADD.
- FETCH: instr_or_data=0, instr_reg_we=1, alu_src_a=0, alu_src_b=1, ADD, pc_src=0, pc_reg_we=1. Always goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, ADD (precomputes the branch target into aluReg). Next state by opcode:
  - lw (100011) / sw (101011) → MEM_ADR
  - R-type (000000) → funct dispatch:
    - jr (001000) → JR
    - sll (000000) / srl (000010) → SHIFT
    - add (100000), sub (100010), and (100100), or (100101), slt (101010) → EXEC
  - beq (000100) / bne (000101) → BRANCH
  - addi (001000) → ADDI_EX
  - j (000010) → JUMP
  - anything else → illegal handling (see Optional Feature)
- MEM_ADR: alu_src_a=1, alu_src_b=2, ADD. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: instr_or_data=1 → MEM_WB.
- MEM_WB: reg_we=1, reg_write_addr=0, reg_write_data=1 → FETCH.
- MEM_WR: instr_or_data=1, mem_we=1 → FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_controller decoded from funct → ALU_WB.
- SHIFT: alu_src_a=2, alu_src_b=4, SLL or SRL → ALU_WB.
- ALU_WB: reg_we=1, reg_write_addr=1, reg_write_data=0 → FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=2, ADD → ADDI_WB.
- ADDI_WB: reg_we=1, reg_write_addr=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1.
  - pc_reg_we = (beq & zero) | (bne & ~zero). This is Mealy, combinational on zero.
  - → FETCH.
- JUMP: pc_src=2, pc_reg_we=1 → FETCH.
- JR: pc_src=3, pc_reg_we=1 → FETCH.
- Cycle counts: lw 5; sw, R-type, shift and addi 4; beq/bne, j and jr 3.
- Only one write enable among reg_we/mem_we is ever high in a given cycle. pc_reg_we and instr_reg_we are both high only in FETCH.
- Reset asserted mid-instruction aborts it; no partial register or memory write occurs after rst rises.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode or R-type funct in DECODE goes to HALT.
  - HALT keeps all enables at 0 and illegal_instr=1, and stays there until rst.
- Undefined: an unknown opcode/funct returns from DECODE to FETCH, behaving as a 2-cycle NOP.
  - illegal_instr is tied to 0 and the HALT state does not exist.

Decomposition:
- Package mips_pkg holds:
  - state enum
  - opcode and funct localparams
  - ALU op codes
  - alu_src_a, alu_src_b and pc_src select encodings
- One sub-module, alu_decoder: combinational funct → alu_controller for R-type, with an unknown-funct flag.

Test Plan:
- Reset, then 0x8C080004 (lw $8,4($0)): states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB. MEM_RD has instr_or_data=1; MEM_WB has reg_we=1, reg_write_data=1, reg_write_addr=0; total 5 cycles.
- sw 0xAC080008: MEM_WR cycle has mem_we=1 and instr_or_data=1; reg_we stays 0 throughout; 4 cycles.
- beq with zero=1 → BRANCH cycle pc_reg_we=1, pc_src=1. Same with zero=0 → pc_reg_we=0. bne shows the inverse.
- R-type funct values:
  - add 0x20 → EXEC alu_controller=010
  - sub 0x22 → 110
  - slt 0x2A → 111
  - sll 0x00 → SHIFT, alu_src_a=2, alu_src_b=4, 011
  - jr 0x08 → JR, pc_src=3
- Assert rst during MEM_WR: mem_we drops to 0 the same cycle; after release, FETCH with instr_reg_we=1.
- Opcode 0x3F:
  - With ILLEGAL_TRAP_EN: HALT, illegal_instr=1, and it holds for 10 cycles.
  - Without it: back to FETCH after DECODE, with illegal_instr=0.
